// File: rtl/decodificador_quadro_pesos.sv
// Frame decoder between the UART receiver and the weight comparator.
// Validates "#<max><min><current>$" ASCII frames and publishes the three weights atomically.
module decodificador_quadro_pesos #(
    parameter int unsigned DIGITOS = 4,
    parameter int unsigned TIMEOUT = 5_000_000,
    parameter int unsigned W       = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx_valido,
    input  logic [7:0]   rx_dado,
    output logic [W-1:0] peso_max,
    output logic [W-1:0] peso_min,
    output logic [W-1:0] peso_atual,
    output logic         quadro_valido,
    output logic         erro_quadro,
    output logic [1:0]   erro_codigo,
    output logic         ocupado
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
    localparam int unsigned CW = 3;

    localparam logic [1:0] ERR_NENHUM    = 2'b00;
    localparam logic [1:0] ERR_CARACTERE = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
    localparam logic [1:0] ERR_MINMAX    = 2'b11;

    typedef enum logic [2:0] {
        OCIOSO,
        DIGITO,
        FIM,
        VALIDA,
        ERRO
    } estadoTipo;

    estadoTipo estado, estadoProx;

    logic [W-1:0]  acc, accProx;
    logic [W-1:0]  stagMax, stagMin, stagAtual;
    logic [1:0]    campo;
    logic [CW-1:0] contDig;
    logic [TW-1:0] timer;
    logic [1:0]    errPend, errSel;

    logic ehDigito, ehInicio, ehFim;
    logic ultimoDigito, expirou;
    logic reiniciar, aceitarDigito;

    assign ehDigito     = (rx_dado >= 8'h30) && (rx_dado <= 8'h39);
    assign ehInicio     = (rx_dado == 8'h23);
    assign ehFim        = (rx_dado == 8'h24);
    assign accProx      = (acc << 3) + (acc << 1) + W'(rx_dado[3:0]);
    assign ultimoDigito = (contDig == CW'(DIGITOS - 1));
    // Fires on the edge at which the counter would reach TIMEOUT-1, so a byte
    // on that same edge still wins and the error pulse lands TIMEOUT cycles after the last byte.
    assign expirou      = (timer == TW'(TIMEOUT - 2));
    assign ocupado      = (estado != OCIOSO);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estadoProx;
        end
    end

    always_comb begin
        estadoProx    = estado;
        errSel        = errPend;
        reiniciar     = 1'b0;
        aceitarDigito = 1'b0;
        case (estado)
            OCIOSO: begin
                if (rx_valido && ehInicio) begin
                    reiniciar  = 1'b1;
                    estadoProx = DIGITO;
                end
            end
            DIGITO: begin
                if (rx_valido) begin
                    if (ehInicio) begin
                        reiniciar = 1'b1;
                    end else if (ehDigito) begin
                        aceitarDigito = 1'b1;
                        if (ultimoDigito && (campo == 2'd2)) begin
                            estadoProx = FIM;
                        end
                    end else begin
                        estadoProx = ERRO;
                        errSel     = ERR_CARACTERE;
                    end
                end else if (expirou) begin
                    estadoProx = ERRO;
                    errSel     = ERR_TIMEOUT;
                end
            end
            FIM: begin
                if (rx_valido) begin
                    if (ehInicio) begin
                        reiniciar  = 1'b1;
                        estadoProx = DIGITO;
                    end else if (ehFim) begin
                        estadoProx = VALIDA;
                    end else begin
                        estadoProx = ERRO;
                        errSel     = ERR_CARACTERE;
                    end
                end else if (expirou) begin
                    estadoProx = ERRO;
                    errSel     = ERR_TIMEOUT;
                end
            end
            VALIDA:  estadoProx = OCIOSO;
            ERRO:    estadoProx = OCIOSO;
            default: estadoProx = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc           <= '0;
            campo         <= '0;
            contDig       <= '0;
            timer         <= '0;
            errPend       <= ERR_NENHUM;
            stagMax       <= '0;
            stagMin       <= '0;
            stagAtual     <= '0;
            peso_max      <= '0;
            peso_min      <= '0;
            peso_atual    <= '0;
            quadro_valido <= 1'b0;
            erro_quadro   <= 1'b0;
            erro_codigo   <= ERR_NENHUM;
        end else begin
            quadro_valido <= 1'b0;
            erro_quadro   <= 1'b0;
            errPend       <= errSel;

            if ((estado == OCIOSO) || rx_valido) begin
                timer <= '0;
            end else if ((estado == DIGITO) || (estado == FIM)) begin
                timer <= timer + TW'(1);
            end

            if (reiniciar) begin
                acc     <= '0;
                campo   <= '0;
                contDig <= '0;
            end else if (aceitarDigito) begin
                if (ultimoDigito) begin
                    acc     <= '0;
                    contDig <= '0;
                    campo   <= campo + 2'd1;
                    case (campo)
                        2'd0:    stagMax   <= accProx;
                        2'd1:    stagMin   <= accProx;
                        default: stagAtual <= accProx;
                    endcase
                end else begin
                    acc     <= accProx;
                    contDig <= contDig + CW'(1);
                end
            end

            if (estado == VALIDA) begin
                if (stagMin > stagMax) begin
                    erro_quadro <= 1'b1;
                    erro_codigo <= ERR_MINMAX;
                end else begin
                    peso_max      <= stagMax;
                    peso_min      <= stagMin;
                    peso_atual    <= stagAtual;
                    quadro_valido <= 1'b1;
                    erro_codigo   <= ERR_NENHUM;
                end
            end

            if (estado == ERRO) begin
                erro_quadro <= 1'b1;
                erro_codigo <= errPend;
            end
        end
    end

endmodule

// File: tb/tb_decodificador_quadro_pesos.sv
// Self-checking bench: frame vector table plus timeout and reset sequences,
// with a scoreboard queue matching every quadro_valido / erro_quadro pulse.
module tb_decodificador_quadro_pesos;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = 1000;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         rx_valido = 1'b0;
    logic [7:0]   rx_dado = 8'h00;
    logic [W-1:0] peso_max, peso_min, peso_atual;
    logic         quadro_valido, erro_quadro, ocupado;
    logic [1:0]   erro_codigo;

    decodificador_quadro_pesos #(.DIGITOS(4), .TIMEOUT(TO), .W(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_valido     (rx_valido),
        .rx_dado       (rx_dado),
        .peso_max      (peso_max),
        .peso_min      (peso_min),
        .peso_atual    (peso_atual),
        .quadro_valido (quadro_valido),
        .erro_quadro   (erro_quadro),
        .erro_codigo   (erro_codigo),
        .ocupado       (ocupado)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       quadro;
        int          kind;     // 0 valid frame, 1 error, 2 no pulse
        int unsigned eMax;
        int unsigned eMin;
        int unsigned eAtual;
        logic [1:0]  eCod;
    } vetorT;

    typedef struct {
        string       nome;
        int          kind;
        int unsigned eMax;
        int unsigned eMin;
        int unsigned eAtual;
        logic [1:0]  eCod;
        int          due;
    } esperadoT;

    esperadoT fila[$];
    esperadoT emDesfile;
    vetorT    vetores[13];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lastEdge = 0;

    int unsigned curMax = 0, curMin = 0, curAtual = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nome, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nome, act, req);
        end
    endtask

    // Scoreboard side: every pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (reset && (quadro_valido || erro_quadro)) begin
            if (fila.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got quadro_valido=%0b erro_quadro=%0b required none",
                         quadro_valido, erro_quadro);
            end else begin
                emDesfile = fila.pop_front();
                check({emDesfile.nome, ".pulse"}, {62'd0, quadro_valido, erro_quadro},
                      (emDesfile.kind == 0) ? 64'd2 : 64'd1);
                check({emDesfile.nome, ".cycle"}, 64'(cyc), 64'(emDesfile.due));
                check({emDesfile.nome, ".peso_max"}, 64'(peso_max), 64'(emDesfile.eMax));
                check({emDesfile.nome, ".peso_min"}, 64'(peso_min), 64'(emDesfile.eMin));
                check({emDesfile.nome, ".peso_atual"}, 64'(peso_atual), 64'(emDesfile.eAtual));
                check({emDesfile.nome, ".erro_codigo"}, 64'(erro_codigo), 64'(emDesfile.eCod));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clock);
        rx_valido = 1'b1;
        rx_dado   = b;
        @(posedge clock);
        #1;
        lastEdge  = cyc;
        rx_valido = 1'b0;
    endtask

    task automatic sendString(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            sendByte(s[i]);
            if (i + 1 < s.len()) idle(gap);
        end
    endtask

    task automatic pushExp(input string nome, input int kind, input int unsigned mx,
                           input int unsigned mn, input int unsigned at, input logic [1:0] cod,
                           input int due);
        esperadoT e;
        e.nome = nome; e.kind = kind; e.eMax = mx; e.eMin = mn; e.eAtual = at;
        e.eCod = cod; e.due = due;
        fila.push_back(e);
    endtask

    task automatic waitDrain(input string nome, input int limite);
        int n = 0;
        while (fila.size() != 0 && n < limite) begin
            @(posedge clock);
            n++;
        end
        check({nome, ".drained"}, 64'(fila.size()), 64'd0);
        fila.delete();
    endtask

    task automatic checkOutputs(input string nome, input int unsigned mx, input int unsigned mn,
                                input int unsigned at, input logic [1:0] cod, input logic oc);
        check({nome, ".out_max"}, 64'(peso_max), 64'(mx));
        check({nome, ".out_min"}, 64'(peso_min), 64'(mn));
        check({nome, ".out_atual"}, 64'(peso_atual), 64'(at));
        check({nome, ".out_codigo"}, 64'(erro_codigo), 64'(cod));
        check({nome, ".ocupado"}, 64'(ocupado), 64'(oc));
    endtask

    task automatic runVector(input vetorT v, input string nome);
        sendString(v.quadro, 19);
        if (v.kind != 2) pushExp(nome, v.kind, v.eMax, v.eMin, v.eAtual, v.eCod, lastEdge + 1);
        waitDrain(nome, 50);
        idle(5);
        checkOutputs(nome, v.eMax, v.eMin, v.eAtual, v.eCod, 1'b0);
        curMax = v.eMax; curMin = v.eMin; curAtual = v.eAtual;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vetores[0]  = '{"#050001000300$",            0, 500,  100,  300, 2'b00};
        vetores[1]  = '{"#0500A",                    1, 500,  100,  300, 2'b01};
        vetores[2]  = '{"#900000000001$",            0, 9000, 0,    1,   2'b00};
        vetores[3]  = '{"#010005000300$",            1, 9000, 0,    1,   2'b11};
        vetores[4]  = '{"#0500#070001000300$",       0, 700,  100,  300, 2'b00};
        vetores[5]  = '{"xyz$",                      2, 700,  100,  300, 2'b00};
        vetores[6]  = '{"#12/",                      1, 700,  100,  300, 2'b01};
        vetores[7]  = '{"#999999990000$",            0, 9999, 9999, 0,   2'b00};
        vetores[8]  = '{"#000100020000$",            1, 9999, 9999, 0,   2'b11};
        vetores[9]  = '{"#12345678901$",             1, 9999, 9999, 0,   2'b01};
        vetores[10] = '{"#0000000000000",            1, 9999, 9999, 0,   2'b01};
        vetores[11] = '{"#123412341234:",            1, 9999, 9999, 0,   2'b01};
        vetores[12] = '{"#000000000000#000200010003$", 0, 2,  1,    3,   2'b00};

        idle(3);
        @(negedge clock);
        reset = 1'b1;
        idle(2);
        checkOutputs("reset", 0, 0, 0, 2'b00, 1'b0);
        check("reset.quadro_valido", 64'(quadro_valido), 64'd0);
        check("reset.erro_quadro", 64'(erro_quadro), 64'd0);

        for (int i = 0; i < 13; i++) begin
            runVector(vetores[i], $sformatf("vec%0d", i));
        end

        // Silence after a partial frame: error pulse exactly TO cycles after the last byte.
        sendString("#0500", 19);
        pushExp("timeout", 1, curMax, curMin, curAtual, 2'b10, lastEdge + TO);
        waitDrain("timeout", TO + 50);
        idle(2);
        checkOutputs("timeout", curMax, curMin, curAtual, 2'b10, 1'b0);

        // A byte on the last permissible edge restarts the count twice in a row.
        sendByte("#");
        idle(1);
        check("near.ocupado_mid", 64'(ocupado), 64'd1);
        idle(18);
        sendString("0500", 19);
        idle(TO - 2);
        sendByte("0");
        idle(TO - 2);
        sendByte("1");
        idle(19);
        sendString("000300$", 19);
        pushExp("near", 0, 500, 100, 300, 2'b00, lastEdge + 1);
        waitDrain("near", 50);
        idle(3);
        checkOutputs("near", 500, 100, 300, 2'b00, 1'b0);

        // Asynchronous reset in the middle of a frame.
        sendString("#0500010", 19);
        idle(3);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkOutputs("async_reset", 0, 0, 0, 2'b00, 1'b0);
        check("async_reset.quadro_valido", 64'(quadro_valido), 64'd0);
        idle(2);
        @(negedge clock);
        reset = 1'b1;
        idle(2);
        sendString("#123405670089$", 19);
        pushExp("after_reset", 0, 1234, 567, 89, 2'b00, lastEdge + 1);
        waitDrain("after_reset", 50);
        idle(3);
        checkOutputs("after_reset", 1234, 567, 89, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decodificador_quadro_pesos.md
Name: decodificador_quadro_pesos

Overview:
- Upstream framing stage between the 8N1 UART receiver and the weight-comparison datapath.
- Consumes the received byte stream and validates fixed-length ASCII frames carrying three decimal weights: max, min, current.
- Converts each weight to unsigned binary and publishes all three atomically with a one-cycle strobe.
- Rejects malformed, stalled and inconsistent frames with an error code.

Parameters:
- DIGITOS, 4: ASCII decimal digits per weight field (1..4).
- TIMEOUT, 5_000_000: clock cycles allowed between consecutive bytes inside a frame (100 ms at 50 MHz).
- W, 16: width of each binary weight output.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_valido  input  1  one-cycle pulse; rx_dado is valid.
- rx_dado  input  8  received ASCII byte.
- peso_max  output  W  last accepted maximum weight, binary.
- peso_min  output  W  last accepted minimum weight, binary.
- peso_atual  output  W  last accepted current weight, binary.
- quadro_valido  output  1  one-cycle pulse when new weights are loaded.
- erro_quadro  output  1  one-cycle pulse on frame rejection.
- erro_codigo  output  2  last error: 00 none, 01 invalid character, 10 timeout, 11 min>max.
- ocupado  output  1  high while a frame is in progress (state not OCIOSO).

Behaviour:
- Frame format: '#' (0x23), then 3*DIGITOS digits ('0'..'9', 0x30..0x39) in field order max, min, current, then '$' (0x24). Leading zeros are mandatory.
- Reset (reset=0, asynchronous): all weight outputs 0, quadro_valido=0, erro_quadro=0, erro_codigo=00, state OCIOSO, accumulators, counters and timeout counter cleared. Reset mid-frame discards the frame.
- FSM states:
  - OCIOSO: only '#' is acted on, moving to DIGITO and clearing the accumulator, field index and digit counter. All other bytes are silently ignored.
  - DIGITO: on a digit, acc <= acc*10 + (rx_dado-0x30), computed in W bits; no overflow is possible for DIGITOS≤4. When the digit counter reaches DIGITOS-1, acc is stored into the staging register for the current field, acc clears and the field index increments. After the 3rd field completes, go to FIM.
  - FIM: '$' goes to VALIDA. A digit here is an invalid character.
  - VALIDA: lasts exactly one cycle. If staged min > staged max (unsigned), raise erro 11. Otherwise load all three outputs together and pulse quadro_valido. Always return to OCIOSO.
  - ERRO: lasts exactly one cycle. Pulse erro_quadro, load erro_codigo, return to OCIOSO.
- '#' received in DIGITO or FIM: resynchronise. Restart the frame, no error, outputs unchanged.
- Any other non-digit in DIGITO, or a non-'$' non-'#' byte in FIM: ERRO with code 01.
- Timeout:
  - The counter clears on every rx_valido and in OCIOSO.
  - It increments every cycle in DIGITO or FIM.
  - When it reaches TIMEOUT-1: ERRO with code 10.
  - rx_valido in the same cycle takes priority; the byte is processed and there is no timeout.
- Bytes arriving during VALIDA or ERRO are ignored. The UART byte period is far larger than one cycle, so no byte can be lost in normal operation.
- Latency: the '$' byte is sampled at edge k, the FSM enters VALIDA at k, and outputs plus quadro_valido are updated at edge k+1. quadro_valido is high for exactly one cycle.
- erro_quadro has the same latency from the offending byte or timeout cycle.
- erro_codigo holds its value until the next error or the next quadro_valido, which clears it to 00.
- On any error, peso_* keep their previous values.
- Only complete, consistent frames ever change the outputs; partial updates are forbidden.

Test Plan:
- Reset, then "#050001000300$" (DIGITOS=4), one byte every 20 cycles → peso_max=500, peso_min=100, peso_atual=300. quadro_valido is one pulse, 1 cycle after '$'. erro_codigo=00; ocupado falls after VALIDA.
- Valid frame, then "#0500A" → erro_quadro pulse, erro_codigo=01, outputs still 500/100/300. A following valid "#900000000001$" loads 9000/0/1 and clears erro_codigo to 00.
- TIMEOUT=1000: "#0500" then silence → erro_quadro exactly 1000 cycles after the last byte, code 10, ocupado returns to 0. A byte at cycle 999 instead resets the count and produces no error.
- "#010005000300$" (min 500 > max 100) → erro_codigo=11, no quadro_valido, outputs unchanged.
- "#0500#070001000300$" → no error pulse; outputs 700/100/300. Stray bytes "xyz$" while idle → no response.
- reset asserted asynchronously mid-frame after "#0500010" → outputs 0 and state OCIOSO immediately. After release, a full valid frame decodes correctly.
